// File: rtl/bram_frame_reader_if.sv
// Pixel stream between the frame reader and its consumer.
// Carries data, valid/ready, end-of-line and start-of-frame sideband.
interface bram_frame_reader_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;
  logic                  m_tuser;

  modport master (
    output m_tdata, m_tvalid, m_tlast, m_tuser,
    input  m_tready
  );

  modport slave (
    input  m_tdata, m_tvalid, m_tlast, m_tuser,
    output m_tready
  );
endinterface

// File: rtl/bram_frame_reader.sv
// Frame buffer read master: streams FRAME_W*FRAME_H pixels from a BRAM port
// through a small credit-gated FIFO onto a valid/ready pixel interface.
module bram_frame_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 19,
  parameter int FRAME_W    = 640,
  parameter int FRAME_H    = 480,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  output logic                  bram_regce,
  output logic                  bram_we,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  bram_frame_reader_if.master   m_axis
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_W * FRAME_H - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_X   = ADDR_WIDTH'(FRAME_W - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_Y   = ADDR_WIDTH'(FRAME_H - 1);

  generate
    if (longint'(FRAME_W) * longint'(FRAME_H) > (longint'(1) << ADDR_WIDTH)) begin : g_chk_frame
      $error("bram_frame_reader: FRAME_W*FRAME_H exceeds the address space");
    end
    if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (FIFO_DEPTH < RD_LATENCY + 1)) begin : g_chk_fifo
      $error("bram_frame_reader: FIFO_DEPTH must be a power of 2 and > RD_LATENCY");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, x_q, y_q;
  logic [RD_LATENCY-1:0]   sr_vld_q, sr_last_q, sr_user_q;
  logic [ENT_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]        fifo_count_q, inflight;
  logic [ENT_W-1:0]        head;
  logic                    rd_en, push, pop, fifo_empty, credit_ok, drain_done;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(sr_vld_q[i]);
  end

  assign push       = sr_vld_q[RD_LATENCY-1];
  assign fifo_empty = (fifo_count_q == '0);
  assign pop        = m_axis.m_tvalid && m_axis.m_tready;
  // Outstanding reads reserve FIFO slots, so returning data always has room.
  assign credit_ok  = ({1'b0, inflight} + {1'b0, fifo_count_q}) < (CNT_W + 1)'(FIFO_DEPTH);
  assign drain_done = (inflight == '0) &&
                      (fifo_empty || ((fifo_count_q == CNT_W'(1)) && pop));

  always_ff @(posedge clka) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rstb) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    rd_en   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN: begin
        busy  = 1'b1;
        rd_en = credit_ok;
        if (rd_en && (idx_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_done) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bram_en    = rd_en;
  assign bram_addr  = rd_en ? idx_q : '0;
  assign bram_regce = 1'b1;
  assign bram_we    = 1'b0;

  always_ff @(posedge clka) begin
    if (!rstb || ((state_q == S_IDLE) && start)) begin
      idx_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (rd_en) begin
      idx_q <= idx_q + ADDR_WIDTH'(1);
      if (x_q == LAST_X) begin
        x_q <= '0;
        y_q <= (y_q == LAST_Y) ? '0 : y_q + ADDR_WIDTH'(1);
      end else begin
        x_q <= x_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Sideband rides alongside the read-valid bit so it lands with its pixel.
  always_ff @(posedge clka) begin
    if (!rstb) begin
      sr_vld_q  <= '0;
      sr_last_q <= '0;
      sr_user_q <= '0;
    end else begin
      sr_vld_q[0]  <= rd_en;
      sr_last_q[0] <= (x_q == LAST_X);
      sr_user_q[0] <= (x_q == '0) && (y_q == '0);
      for (int i = 1; i < RD_LATENCY; i++) begin
        sr_vld_q[i]  <= sr_vld_q[i-1];
        sr_last_q[i] <= sr_last_q[i-1];
        sr_user_q[i] <= sr_user_q[i-1];
      end
    end
  end

  always_ff @(posedge clka) begin
    if (!rstb) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count_q <= fifo_count_q + CNT_W'(1);
        2'b01:   fifo_count_q <= fifo_count_q - CNT_W'(1);
        default: fifo_count_q <= fifo_count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the pointers and count define which entries
  // are valid, and leaving the array unreset lets it map onto distributed RAM.
  always_ff @(posedge clka) begin
    if (push) fifo_mem[wr_ptr_q] <= {sr_last_q[RD_LATENCY-1], sr_user_q[RD_LATENCY-1], bram_dout};
  end

  assign head            = fifo_mem[rd_ptr_q];
  assign m_axis.m_tvalid = !fifo_empty;
  assign m_axis.m_tdata  = fifo_empty ? '0   : head[DATA_WIDTH-1:0];
  assign m_axis.m_tuser  = fifo_empty ? 1'b0 : head[DATA_WIDTH];
  assign m_axis.m_tlast  = fifo_empty ? 1'b0 : head[DATA_WIDTH+1];

  a_fifo_no_overflow: assert property (@(posedge clka) disable iff (!rstb)
    push |-> (fifo_count_q < CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_bram_frame_reader.sv
// Self-checking bench for bram_frame_reader on a 4x3 frame with a
// 2-cycle BRAM model preloaded so that data equals address.
module tb_bram_frame_reader;
  localparam int FW = 4;
  localparam int FH = 3;
  localparam int AW = 19;
  localparam int DW = 8;

  logic          clka;
  logic          rstb;
  logic          start;
  logic          busy, done;
  logic [AW-1:0] bram_addr;
  logic          bram_en, bram_regce, bram_we;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] bram_r1;

  bram_frame_reader_if #(.DATA_WIDTH(DW)) m_axis_if ();

  bram_frame_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_W(FW), .FRAME_H(FH),
    .RD_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clka(clka), .rstb(rstb), .start(start), .busy(busy), .done(done),
    .bram_addr(bram_addr), .bram_en(bram_en), .bram_regce(bram_regce),
    .bram_we(bram_we), .bram_dout(bram_dout), .m_axis(m_axis_if)
  );

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  // BRAM with output register: address registered, then data registered.
  initial begin
    bram_r1   = '0;
    bram_dout = '0;
  end
  always @(posedge clka) begin
    if (bram_en)    bram_r1   <= DW'(bram_addr);
    if (bram_regce) bram_dout <= bram_r1;
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  beat_t         exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            beats = 0;

  logic          sn_en, sn_valid, sn_last, sn_user, sn_busy, sn_done;
  logic [AW-1:0] sn_addr;
  logic [DW-1:0] sn_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference frame: raster order, pixel value = linear index.
  function automatic void new_frame();
    beat_t b;
    exp_q.delete();
    beats = 0;
    for (int y = 0; y < FH; y++) begin
      for (int x = 0; x < FW; x++) begin
        b.data = DW'(y * FW + x);
        b.last = (x == FW - 1);
        b.user = (x == 0) && (y == 0);
        exp_q.push_back(b);
      end
    end
  endfunction

  // One clock cycle: drive just after posedge, sample and score at negedge.
  task automatic do_cycle(input logic st, input logic rdy, input logic rst_b);
    beat_t b;
    start              = st;
    m_axis_if.m_tready = rdy;
    rstb               = rst_b;
    @(negedge clka);
    sn_en    = bram_en;
    sn_addr  = bram_addr;
    sn_valid = m_axis_if.m_tvalid;
    sn_data  = m_axis_if.m_tdata;
    sn_last  = m_axis_if.m_tlast;
    sn_user  = m_axis_if.m_tuser;
    sn_busy  = busy;
    sn_done  = done;
    if (rst_b && sn_valid && rdy) begin
      beats++;
      if (exp_q.size() == 0) begin
        check("sb_extra_beat", beats, FW * FH);
      end else begin
        b = exp_q.pop_front();
        check("sb_data", sn_data, b.data);
        check("sb_last", sn_last, b.last);
        check("sb_user", sn_user, b.user);
      end
    end
    @(posedge clka);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  sn_busy,  0);
    check({tag, "_done"},  sn_done,  0);
    check({tag, "_en"},    sn_en,    0);
    check({tag, "_valid"}, sn_valid, 0);
    check({tag, "_last"},  sn_last,  0);
    check({tag, "_user"},  sn_user,  0);
    check({tag, "_data"},  sn_data,  0);
    check({tag, "_addr"},  sn_addr,  0);
  endtask

  task automatic run_until_done(input string tag, input bit rand_rdy,
                                input bit extra_starts, input bit first_start);
    int c;
    bit fin;
    c   = 0;
    fin = 1'b0;
    while (!fin && c < 300) begin
      do_cycle((first_start && c == 0) || (extra_starts && (c == 2 || c == 6)),
               rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1, 1'b1);
      if (sn_done) fin = 1'b1;
      c++;
    end
    check({tag, "_done_seen"}, fin, 1);
    check({tag, "_beats"}, beats, FW * FH);
    check({tag, "_left"}, exp_q.size(), 0);
    do_cycle(1'b0, 1'b1, 1'b1);
    check({tag, "_post_busy"},  sn_busy,  0);
    check({tag, "_post_done"},  sn_done,  0);
    check({tag, "_post_valid"}, sn_valid, 0);
  endtask

  initial begin
    int reads;
    void'($urandom(32'd2024));
    rstb               = 1'b0;
    start              = 1'b0;
    m_axis_if.m_tready = 1'b0;
    @(posedge clka);
    #1;

    // Reset values with random inputs.
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      check_idle("rst_hold");
    end
    do_cycle(1'b0, 1'b1, 1'b1);
    check_idle("rst_release");
    check("rst_regce", bram_regce, 1);
    check("rst_we", bram_we, 0);

    // Full rate, cycle-exact timing.
    new_frame();
    for (int c = 0; c <= 18; c++) begin
      do_cycle(c == 0, 1'b1, 1'b1);
      check("fr_en", sn_en, (c >= 1 && c <= 12));
      if (c >= 1 && c <= 12) check("fr_addr", sn_addr, c - 1);
      check("fr_valid", sn_valid, (c >= 4 && c <= 15));
      if (c >= 4 && c <= 15) check("fr_data", sn_data, c - 4);
      check("fr_done", sn_done, c == 16);
      check("fr_busy", sn_busy, (c >= 1 && c <= 15));
    end
    check("fr_beats", beats, FW * FH);

    // Backpressure from cycle 0, then release.
    new_frame();
    reads = 0;
    for (int c = 0; c < 12; c++) begin
      do_cycle(c == 0, 1'b0, 1'b1);
      if (sn_en) reads++;
      if (c >= 5) check("bp_en_low", sn_en, 0);
      if (c >= 4) begin
        check("bp_valid", sn_valid, 1);
        check("bp_hold_data", sn_data, 0);
        check("bp_hold_user", sn_user, 1);
      end
    end
    check("bp_reads", reads, 4);
    run_until_done("bp_release", 1'b0, 1'b0, 1'b0);

    // Random ready with stray start pulses mid-frame.
    new_frame();
    run_until_done("rand_rdy", 1'b1, 1'b1, 1'b1);

    // A second frame after done starts again at pixel 0.
    new_frame();
    run_until_done("second", 1'b1, 1'b0, 1'b1);

    // Reset mid-frame, then a clean restart.
    new_frame();
    for (int c = 0; c <= 7; c++) do_cycle(c == 0, 1'b1, c != 7);
    for (int c = 8; c < 18; c++) begin
      do_cycle(1'b0, 1'b1, 1'b1);
      check_idle("mid_rst");
    end
    new_frame();
    run_until_done("restart", 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
